// File: rtl/noc_pkg.sv
// Shared types and default widths for the NoC input and output stages.
package noc_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam int DEF_TDATAW = 32;
  localparam int DEF_TDESTW = 4;
  localparam int DEF_TIDW   = 2;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock circular FIFO with registered-head read (no fall-through).
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Overflowing pushes and underflowing pops are ignored here.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/input_module.sv
// Host-fed packet source: buffers pushed words and emits them as an
// AXI-Stream burst with latched TID/TDEST and TLAST on the final beat.
module input_module
  import noc_pkg::*;
#(
  parameter int TDATAW = DEF_TDATAW,
  parameter int TDESTW = DEF_TDESTW,
  parameter int TIDW   = DEF_TIDW,
  parameter int DEPTH  = 8,
  parameter int LENW   = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              WR_EN,
  input  logic [TDATAW-1:0] WR_DATA,
  output logic              FULL,
  output logic              DROP,
  input  logic              START,
  input  logic [LENW-1:0]   PKT_LEN,
  input  logic [TDESTW-1:0] PKT_DEST,
  input  logic [TIDW-1:0]   PKT_ID,
  output logic              BUSY,
  output logic              PKT_DONE,
  output logic              AXIS_M_TVALID,
  input  logic              AXIS_M_TREADY,
  output logic [TDATAW-1:0] AXIS_M_TDATA,
  output logic              AXIS_M_TLAST,
  output logic [TIDW-1:0]   AXIS_M_TID,
  output logic [TDESTW-1:0] AXIS_M_TDEST
);

  localparam int CW = $clog2(DEPTH) + 1;

  // Handshake: a beat transfers on any rising CLK edge where TVALID and
  // TREADY are both high; TVALID is never a function of TREADY, and the
  // beat fields hold steady while TVALID waits because the FIFO head only
  // moves on a transfer.

  state_t            state;
  logic [LENW-1:0]   len_q;
  logic [LENW-1:0]   beat_q;
  logic [TDESTW-1:0] dest_q;
  logic [TIDW-1:0]   id_q;
  logic              drop_q;
  logic              done_q;

  logic              fifo_full;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [TDATAW-1:0] fifo_head;
  logic              tvalid;
  logic              tlast;
  logic              hs;

  sync_fifo #(
    .WIDTH (TDATAW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (CLK),
    .rst   (RST),
    .push  (WR_EN && !fifo_full),
    .pop   (hs),
    .din   (WR_DATA),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign tvalid = (state == SEND) && !fifo_empty;
  assign tlast  = tvalid && (beat_q == len_q - LENW'(1));
  assign hs     = tvalid && AXIS_M_TREADY;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state  <= IDLE;
      len_q  <= '0;
      beat_q <= '0;
      dest_q <= '0;
      id_q   <= '0;
      drop_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      drop_q <= WR_EN && fifo_full;
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (START && (PKT_LEN != '0)) begin
            len_q  <= PKT_LEN;
            dest_q <= PKT_DEST;
            id_q   <= PKT_ID;
            beat_q <= '0;
            state  <= SEND;
          end
        end
        SEND: begin
          if (hs) begin
            // Wrap to zero on the last beat so the counter stays below len.
            if (tlast) begin
              beat_q <= '0;
              done_q <= 1'b1;
              state  <= IDLE;
            end else begin
              beat_q <= beat_q + LENW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign FULL          = (fifo_count == CW'(DEPTH));
  assign DROP          = drop_q;
  assign BUSY          = (state == SEND);
  assign PKT_DONE      = done_q;
  assign AXIS_M_TVALID = tvalid;
  assign AXIS_M_TDATA  = fifo_head;
  assign AXIS_M_TLAST  = tlast;
  assign AXIS_M_TID    = id_q;
  assign AXIS_M_TDEST  = dest_q;

endmodule

// File: tb/tb_input_module.sv
// Directed bench for input_module: cycle-by-cycle checks plus a beat
// scoreboard fed with every word the host is expected to see emitted.
module tb_input_module;

  localparam int TDATAW = 32;
  localparam int TDESTW = 4;
  localparam int TIDW   = 2;
  localparam int DEPTH  = 8;
  localparam int LENW   = 4;

  logic              CLK = 1'b0;
  logic              RST;
  logic              WR_EN;
  logic [TDATAW-1:0] WR_DATA;
  logic              FULL;
  logic              DROP;
  logic              START;
  logic [LENW-1:0]   PKT_LEN;
  logic [TDESTW-1:0] PKT_DEST;
  logic [TIDW-1:0]   PKT_ID;
  logic              BUSY;
  logic              PKT_DONE;
  logic              AXIS_M_TVALID;
  logic              AXIS_M_TREADY;
  logic [TDATAW-1:0] AXIS_M_TDATA;
  logic              AXIS_M_TLAST;
  logic [TIDW-1:0]   AXIS_M_TID;
  logic [TDESTW-1:0] AXIS_M_TDEST;

  int checks = 0;
  int errors = 0;
  int hs_cnt = 0;
  int done_cnt = 0;
  logic [TDATAW-1:0] exp_q[$];

  // ---------------- clock / reset ----------------
  always #5 CLK = ~CLK;

  input_module #(
    .TDATAW (TDATAW),
    .TDESTW (TDESTW),
    .TIDW   (TIDW),
    .DEPTH  (DEPTH),
    .LENW   (LENW)
  ) dut (
    .CLK           (CLK),
    .RST           (RST),
    .WR_EN         (WR_EN),
    .WR_DATA       (WR_DATA),
    .FULL          (FULL),
    .DROP          (DROP),
    .START         (START),
    .PKT_LEN       (PKT_LEN),
    .PKT_DEST      (PKT_DEST),
    .PKT_ID        (PKT_ID),
    .BUSY          (BUSY),
    .PKT_DONE      (PKT_DONE),
    .AXIS_M_TVALID (AXIS_M_TVALID),
    .AXIS_M_TREADY (AXIS_M_TREADY),
    .AXIS_M_TDATA  (AXIS_M_TDATA),
    .AXIS_M_TLAST  (AXIS_M_TLAST),
    .AXIS_M_TID    (AXIS_M_TID),
    .AXIS_M_TDEST  (AXIS_M_TDEST)
  );

  // ---------------- driver tasks ----------------
  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_word(input logic [TDATAW-1:0] d, input bit keep);
    WR_EN   = 1'b1;
    WR_DATA = d;
    if (keep) exp_q.push_back(d);
    tick();
    WR_EN   = 1'b0;
  endtask

  task automatic start_pkt(input logic [LENW-1:0] len, input logic [TDESTW-1:0] dest,
                           input logic [TIDW-1:0] id);
    START    = 1'b1;
    PKT_LEN  = len;
    PKT_DEST = dest;
    PKT_ID   = id;
    tick();
    START    = 1'b0;
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic              prev_stall = 1'b0;
  logic [TDATAW-1:0] prev_data;
  logic              prev_last;

  always @(negedge CLK) begin
    if (prev_stall) begin
      check("hold_valid", 32'(AXIS_M_TVALID), 32'd1);
      check("hold_data", AXIS_M_TDATA, prev_data);
      check("hold_last", 32'(AXIS_M_TLAST), 32'(prev_last));
    end
    if (AXIS_M_TVALID === 1'b1 && AXIS_M_TREADY === 1'b1) begin
      hs_cnt++;
      if (exp_q.size() == 0) check("beat_unexp", 32'(exp_q.size()), 32'd1);
      else check("beat_data", AXIS_M_TDATA, exp_q.pop_front());
    end
    if (PKT_DONE === 1'b1) done_cnt++;
    prev_stall = (AXIS_M_TVALID === 1'b1) && !AXIS_M_TREADY && !RST;
    prev_data  = AXIS_M_TDATA;
    prev_last  = AXIS_M_TLAST;
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [4:0] pat;
    int hs_before;
    RST = 1'b1; WR_EN = 1'b0; WR_DATA = '0; START = 1'b0;
    PKT_LEN = '0; PKT_DEST = '0; PKT_ID = '0; AXIS_M_TREADY = 1'b0;
    tick(); tick();
    check("rst_busy", 32'(BUSY), 32'd0);
    check("rst_full", 32'(FULL), 32'd0);
    check("rst_tvalid", 32'(AXIS_M_TVALID), 32'd0);
    check("rst_tlast", 32'(AXIS_M_TLAST), 32'd0);
    check("rst_drop", 32'(DROP), 32'd0);
    check("rst_done", 32'(PKT_DONE), 32'd0);
    check("rst_tdest", 32'(AXIS_M_TDEST), 32'd0);
    check("rst_tid", 32'(AXIS_M_TID), 32'd0);
    RST = 1'b0;

    // 3-beat packet, TREADY held high
    for (int i = 0; i < 3; i++) push_word(32'hA0 + i, 1'b1);
    AXIS_M_TREADY = 1'b1;
    start_pkt(4'd3, 4'd5, 2'd2);
    for (int i = 0; i < 3; i++) begin
      check("s1_valid", 32'(AXIS_M_TVALID), 32'd1);
      check("s1_last", 32'(AXIS_M_TLAST), 32'(i == 2));
      check("s1_tdest", 32'(AXIS_M_TDEST), 32'd5);
      check("s1_tid", 32'(AXIS_M_TID), 32'd2);
      check("s1_busy", 32'(BUSY), 32'd1);
      tick();
    end
    check("s1_done", 32'(PKT_DONE), 32'd1);
    check("s1_busy_end", 32'(BUSY), 32'd0);
    check("s1_valid_end", 32'(AXIS_M_TVALID), 32'd0);
    tick();
    check("s1_done_pulse", 32'(PKT_DONE), 32'd0);

    // same packet under TREADY pattern 1,0,0,1,1
    AXIS_M_TREADY = 1'b0;
    for (int i = 0; i < 3; i++) push_word(32'hA0 + i, 1'b1);
    hs_before = hs_cnt;
    start_pkt(4'd3, 4'd5, 2'd2);
    pat = 5'b11001;
    for (int i = 0; i < 5; i++) begin
      AXIS_M_TREADY = pat[i];
      check("s2_valid", 32'(AXIS_M_TVALID), 32'd1);
      check("s2_last", 32'(AXIS_M_TLAST), 32'(i == 4));
      tick();
    end
    check("s2_done", 32'(PKT_DONE), 32'd1);
    check("s2_hs", 32'(hs_cnt - hs_before), 32'd3);

    // underrun mid-packet: 2 words, gap, then 2 more
    AXIS_M_TREADY = 1'b1;
    push_word(32'hB0, 1'b1);
    push_word(32'hB1, 1'b1);
    start_pkt(4'd4, 4'd1, 2'd0);
    check("s3_valid1", 32'(AXIS_M_TVALID), 32'd1);
    tick();
    check("s3_valid2", 32'(AXIS_M_TVALID), 32'd1);
    tick();
    check("s3_gap_a", 32'(AXIS_M_TVALID), 32'd0);
    check("s3_gap_busy", 32'(BUSY), 32'd1);
    tick();
    check("s3_gap_b", 32'(AXIS_M_TVALID), 32'd0);
    WR_EN = 1'b1; WR_DATA = 32'hB2; exp_q.push_back(32'hB2);
    tick();
    check("s3_valid3", 32'(AXIS_M_TVALID), 32'd1);
    check("s3_last3", 32'(AXIS_M_TLAST), 32'd0);
    WR_DATA = 32'hB3; exp_q.push_back(32'hB3);
    tick();
    WR_EN = 1'b0;
    check("s3_valid4", 32'(AXIS_M_TVALID), 32'd1);
    check("s3_last4", 32'(AXIS_M_TLAST), 32'd1);
    tick();
    check("s3_done", 32'(PKT_DONE), 32'd1);

    // overflow: 9 pushes into an 8-deep FIFO
    AXIS_M_TREADY = 1'b0;
    for (int i = 0; i < 7; i++) push_word(32'hC0 + i, 1'b1);
    check("s4_full7", 32'(FULL), 32'd0);
    push_word(32'hC7, 1'b1);
    check("s4_full8", 32'(FULL), 32'd1);
    check("s4_nodrop", 32'(DROP), 32'd0);
    push_word(32'hC8, 1'b0);
    check("s4_drop", 32'(DROP), 32'd1);
    check("s4_full9", 32'(FULL), 32'd1);
    tick();
    check("s4_drop_pulse", 32'(DROP), 32'd0);
    AXIS_M_TREADY = 1'b1;
    start_pkt(4'd8, 4'd2, 2'd1);
    for (int i = 0; i < 8; i++) begin
      check("s4_valid", 32'(AXIS_M_TVALID), 32'd1);
      check("s4_last", 32'(AXIS_M_TLAST), 32'(i == 7));
      tick();
    end
    check("s4_done", 32'(PKT_DONE), 32'd1);
    check("s4_full_end", 32'(FULL), 32'd0);

    // illegal len, START during SEND, START in the PKT_DONE cycle
    start_pkt(4'd0, 4'd6, 2'd1);
    check("s5_len0_busy", 32'(BUSY), 32'd0);
    for (int i = 0; i < 3; i++) push_word(32'hD0 + i, 1'b1);
    start_pkt(4'd2, 4'd3, 2'd1);
    AXIS_M_TREADY = 1'b0;
    START = 1'b1; PKT_LEN = 4'd5; PKT_DEST = 4'd9; PKT_ID = 2'd3;
    tick();
    START = 1'b0;
    check("s5_busy", 32'(BUSY), 32'd1);
    check("s5_tdest", 32'(AXIS_M_TDEST), 32'd3);
    check("s5_tid", 32'(AXIS_M_TID), 32'd1);
    check("s5_last0", 32'(AXIS_M_TLAST), 32'd0);
    AXIS_M_TREADY = 1'b1;
    tick();
    check("s5_last1", 32'(AXIS_M_TLAST), 32'd1);
    tick();
    check("s5_done", 32'(PKT_DONE), 32'd1);
    check("s5_idle", 32'(BUSY), 32'd0);
    start_pkt(4'd1, 4'd7, 2'd0);
    check("s5_b2b_busy", 32'(BUSY), 32'd1);
    check("s5_b2b_last", 32'(AXIS_M_TLAST), 32'd1);
    check("s5_b2b_tdest", 32'(AXIS_M_TDEST), 32'd7);
    check("s5_b2b_nodone", 32'(PKT_DONE), 32'd0);
    tick();
    check("s5_b2b_done", 32'(PKT_DONE), 32'd1);
    tick();
    check("s5_single_done", 32'(PKT_DONE), 32'd0);

    // reset after the first of three beats
    push_word(32'hE0, 1'b1);
    push_word(32'hE1, 1'b0);
    push_word(32'hE2, 1'b0);
    start_pkt(4'd3, 4'd4, 2'd3);
    check("s6_valid", 32'(AXIS_M_TVALID), 32'd1);
    tick();
    RST = 1'b1;
    AXIS_M_TREADY = 1'b0;
    tick();
    RST = 1'b0;
    check("s6_rst_valid", 32'(AXIS_M_TVALID), 32'd0);
    check("s6_rst_busy", 32'(BUSY), 32'd0);
    check("s6_rst_full", 32'(FULL), 32'd0);
    check("s6_rst_done", 32'(PKT_DONE), 32'd0);
    tick();
    check("s6_no_done", 32'(PKT_DONE), 32'd0);
    AXIS_M_TREADY = 1'b1;
    start_pkt(4'd1, 4'd6, 2'd2);
    check("s6_empty_busy", 32'(BUSY), 32'd1);
    check("s6_empty_valid", 32'(AXIS_M_TVALID), 32'd0);
    push_word(32'hF0, 1'b1);
    check("s6_f0_valid", 32'(AXIS_M_TVALID), 32'd1);
    check("s6_f0_last", 32'(AXIS_M_TLAST), 32'd1);
    tick();
    check("s6_f0_done", 32'(PKT_DONE), 32'd1);
    tick();

    // ---------------- final report ----------------
    check("total_done", 32'(done_cnt), 32'd7);
    check("total_hs", 32'(hs_cnt), 32'd23);
    check("exp_q_empty", 32'(exp_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/input_module.md
Name: input_module

Overview:
- Source stage that sits directly upstream of the NoC output stage.
- A host pushes data words into an internal FIFO, then issues a packet command with length, destination and ID.
- The block emits the packet as an AXI-Stream master burst, asserting TLAST on the final beat.
- It honours TREADY backpressure from the downstream consumer.

Parameters:
- TDATAW, 32, data width of host words and AXIS_M_TDATA
- TDESTW, 4, width of destination field
- TIDW, 2, width of packet ID field
- DEPTH, 8, FIFO depth in words; must be a power of 2, at least 2
- LENW, 4, width of packet length field; max packet = 2**LENW-1 beats

Ports:
- CLK  in  1  clock
- RST  in  1  reset
- WR_EN  in  1  host push of WR_DATA into FIFO
- WR_DATA  in  TDATAW  host data word
- FULL  out  1  FIFO full; a push in this cycle is dropped
- DROP  out  1  one-cycle pulse: a push was dropped because FIFO was full
- START  in  1  packet command strobe
- PKT_LEN  in  LENW  beats in packet; 0 is an illegal command
- PKT_DEST  in  TDESTW  destination for whole packet
- PKT_ID  in  TIDW  ID for whole packet
- BUSY  out  1  packet in flight; START is ignored while high
- PKT_DONE  out  1  one-cycle pulse after the last beat handshakes
- AXIS_M_TVALID  out  1  beat valid
- AXIS_M_TREADY  in  1  downstream ready
- AXIS_M_TDATA  out  TDATAW  beat data (FIFO head)
- AXIS_M_TLAST  out  1  final beat of packet
- AXIS_M_TID  out  TIDW  latched PKT_ID
- AXIS_M_TDEST  out  TDESTW  latched PKT_DEST

Behaviour:
- Clock and reset: one clock, CLK. RST is synchronous and active-high, sampled on the rising edge of CLK.
- Reset values:
  - FIFO pointers and count = 0, so FULL=0 and the FIFO is empty.
  - State = IDLE, so BUSY=0.
  - DROP=0, PKT_DONE=0, AXIS_M_TVALID=0, AXIS_M_TLAST=0.
  - Latched len, dest and id = 0; beat counter = 0.
- Reset mid-packet: the packet is abandoned, the FIFO contents are discarded, and no PKT_DONE is issued.
- FIFO:
  - Circular buffer with LENW-independent pointers of log2(DEPTH) bits that wrap naturally; count is log2(DEPTH)+1 bits.
  - FULL is combinational: count==DEPTH.
  - A push with WR_EN=1 and FULL=0 writes mem[wr_ptr] and advances wr_ptr.
  - A push with WR_EN=1 and FULL=1 is discarded, and DROP pulses high in the next cycle. This holds even if a pop occurs in the same cycle.
  - Push and pop in the same cycle when not full: count is unchanged, both pointers advance.
  - A push into an empty FIFO is visible at the head one cycle later; there is no fall-through.
- FSM:
  - IDLE: on START=1 with PKT_LEN!=0, latch len/dest/id, clear the beat counter, and go to SEND next cycle. START with PKT_LEN==0 is ignored.
  - SEND:
    - BUSY=1.
    - AXIS_M_TVALID = FIFO not empty (combinational from the registered count).
    - AXIS_M_TDATA = mem[rd_ptr].
    - AXIS_M_TLAST = TVALID and (beat==len-1).
    - TID and TDEST come from the latched values.
  - Handshake (TVALID & TREADY): pop the FIFO and increment beat.
  - On a handshake with TLAST: return to IDLE, and PKT_DONE=1 for exactly the next cycle.
  - START during SEND is ignored. START in the PKT_DONE cycle (state already IDLE) is accepted.
- AXI-Stream rules:
  - Once TVALID is high, TDATA, TLAST, TID and TDEST stay stable until the handshake, because the head changes only on pop.
  - TVALID never depends on TREADY.
  - If the FIFO underruns mid-packet, TVALID drops. The packet resumes when data arrives; no beat is skipped or duplicated.
- Minimum latency: START at cycle 0 with data already present gives TVALID at cycle 1. With TREADY held high, an N-beat packet completes N cycles later.
- Width rule: the beat counter is LENW bits and never exceeds len-1.

Decomposition:
- Package noc_pkg:
  - typedef for the FSM state enum {IDLE, SEND}.
  - Default width constants TDATAW/TDESTW/TIDW shared with the output stage.
- Sub-module sync_fifo (parameters WIDTH, DEPTH; ports push, pop, din, dout, full, empty, count), instantiated once.
- The FSM and AXI-Stream logic live in input_module.

Test Plan:
- Push 0xA0..0xA2, START len=3 dest=5 id=2, TREADY=1 → TVALID at cycles 1-3; TDATA A0,A1,A2; TLAST only on A2; TDEST=5, TID=2; PKT_DONE one cycle after A2; BUSY low after.
- Same packet with TREADY toggling 1,0,0,1,1 → TDATA/TLAST held stable while TREADY=0; exactly 3 handshakes in order; no duplicates.
- START len=4 with 2 words in FIFO, push 2 more 3 cycles later → TVALID low during the gap; beats 3-4 follow; TLAST on the 4th.
- Push 9 words with DEPTH=8, no START → FULL after 8; 9th dropped; DROP pulses once; later a packet of len 8 returns the first 8 words.
- START len=0, then START during SEND → both ignored; only the original packet is emitted, with a single PKT_DONE.
- RST mid-packet after 1 of 3 beats → TVALID=0, BUSY=0, FULL=0 next cycle; FIFO empty; no PKT_DONE.
